// File: rtl/divider_iter.sv
// divider_iter: iterative restoring integer divider with valid/ready on both
// sides. Each request selects signed (truncating, C semantics) or unsigned
// division. BITS_PER_CYCLE restoring steps are retired per CALC cycle. One
// operation is in flight at a time, and the result is held until consumed.
//
// Parameters:
//   BIT_DEPTH      - operand/result width (>= 2, divisible by BITS_PER_CYCLE)
//   BITS_PER_CYCLE - restoring steps per CALC cycle (1, 2 or 4)
// Ports:
//   clk, reset          - rising-edge clock; async active-high reset
//   in_valid/in_ready   - request handshake (in_ready only in IDLE)
//   in_signed           - 1: two's-complement division, 0: unsigned
//   dividend_in         - dividend, sampled only on the accepting edge
//   divisor_in          - divisor, sampled only on the accepting edge
//   out_valid/out_ready - result handshake (out_valid only in DONE)
//   quotient, remainder - registered results
//   div_by_zero         - current result came from a zero divisor
//   overflow            - current result came from signed MIN / -1
module divider_iter #(
  parameter int unsigned BIT_DEPTH      = 32,
  parameter int unsigned BITS_PER_CYCLE = 1
) (
  input  logic                 clk,
  input  logic                 reset,
  input  logic                 in_valid,
  output logic                 in_ready,
  input  logic                 in_signed,
  input  logic [BIT_DEPTH-1:0] dividend_in,
  input  logic [BIT_DEPTH-1:0] divisor_in,
  output logic                 out_valid,
  input  logic                 out_ready,
  output logic [BIT_DEPTH-1:0] quotient,
  output logic [BIT_DEPTH-1:0] remainder,
  output logic                 div_by_zero,
  output logic                 overflow
);

  localparam int unsigned STEPS = BIT_DEPTH / BITS_PER_CYCLE;
  localparam int unsigned CNT_W = $clog2(STEPS + 1);

  typedef enum logic [1:0] {
    S_IDLE,
    S_CALC,
    S_FIX,
    S_DONE
  } state_t;

  state_t               state_q, state_d;
  // Working dividend: shifts left each step; quotient bits enter at the LSB.
  logic [BIT_DEPTH-1:0] dvd_q, dvd_d;
  logic [BIT_DEPTH-1:0] dvs_q, dvs_d;
  // One extra bit so the trial subtraction's sign is visible at the MSB.
  logic [BIT_DEPTH:0]   rem_q, rem_d;
  logic [CNT_W-1:0]     cnt_q, cnt_d;
  logic                 neg_quo_q, neg_quo_d;
  logic                 neg_rem_q, neg_rem_d;
  logic [BIT_DEPTH-1:0] quotient_q, quotient_d;
  logic [BIT_DEPTH-1:0] remainder_q, remainder_d;
  logic                 dbz_q, dbz_d;
  logic                 ovf_q, ovf_d;

  logic [BIT_DEPTH-1:0] min_pat;
  logic                 dvd_neg, dvs_neg;
  logic [BIT_DEPTH-1:0] dvd_abs, dvs_abs;
  logic [BIT_DEPTH:0]   step_rem;
  logic [BIT_DEPTH-1:0] step_dvd;
  logic [BIT_DEPTH:0]   step_trial;

  assign min_pat = {1'b1, {(BIT_DEPTH-1){1'b0}}};
  assign dvd_neg = in_signed & dividend_in[BIT_DEPTH-1];
  assign dvs_neg = in_signed & divisor_in[BIT_DEPTH-1];
  // Negating MIN wraps back to MIN, which read as unsigned is the correct magnitude.
  assign dvd_abs = dvd_neg ? (~dividend_in + 1'b1) : dividend_in;
  assign dvs_abs = dvs_neg ? (~divisor_in + 1'b1) : divisor_in;

  // BITS_PER_CYCLE chained restoring steps, MSB of the dividend first.
  always_comb begin
    step_rem   = rem_q;
    step_dvd   = dvd_q;
    step_trial = '0;
    for (int unsigned i = 0; i < BITS_PER_CYCLE; i++) begin
      step_rem   = {step_rem[BIT_DEPTH-1:0], step_dvd[BIT_DEPTH-1]};
      step_dvd   = {step_dvd[BIT_DEPTH-2:0], 1'b0};
      step_trial = step_rem - {1'b0, dvs_q};
      if (!step_trial[BIT_DEPTH]) begin
        step_rem    = step_trial;
        step_dvd[0] = 1'b1;
      end
    end
  end

  always_comb begin
    state_d     = state_q;
    dvd_d       = dvd_q;
    dvs_d       = dvs_q;
    rem_d       = rem_q;
    cnt_d       = cnt_q;
    neg_quo_d   = neg_quo_q;
    neg_rem_d   = neg_rem_q;
    quotient_d  = quotient_q;
    remainder_d = remainder_q;
    dbz_d       = dbz_q;
    ovf_d       = ovf_q;

    unique case (state_q)
      S_IDLE: begin
        if (in_valid) begin
          dbz_d = 1'b0;
          ovf_d = 1'b0;
          if (divisor_in == '0) begin
            quotient_d  = '0;
            remainder_d = '0;
            dbz_d       = 1'b1;
            state_d     = S_DONE;
          end else if (in_signed && dividend_in == min_pat && divisor_in == '1) begin
            quotient_d  = min_pat;
            remainder_d = '0;
            ovf_d       = 1'b1;
            state_d     = S_DONE;
          end else begin
            dvd_d     = dvd_abs;
            dvs_d     = dvs_abs;
            neg_quo_d = dvd_neg ^ dvs_neg;
            neg_rem_d = dvd_neg;
            rem_d     = '0;
            cnt_d     = CNT_W'(STEPS);
            state_d   = S_CALC;
          end
        end
      end
      S_CALC: begin
        dvd_d = step_dvd;
        rem_d = step_rem;
        cnt_d = cnt_q - 1'b1;
        if (cnt_q == CNT_W'(1)) begin
          state_d = S_FIX;
        end
      end
      S_FIX: begin
        quotient_d  = neg_quo_q ? (~dvd_q + 1'b1) : dvd_q;
        remainder_d = neg_rem_q ? (~rem_q[BIT_DEPTH-1:0] + 1'b1) : rem_q[BIT_DEPTH-1:0];
        state_d     = S_DONE;
      end
      S_DONE: begin
        if (out_ready) begin
          state_d = S_IDLE;
        end
      end
      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q     <= S_IDLE;
      dvd_q       <= '0;
      dvs_q       <= '0;
      rem_q       <= '0;
      cnt_q       <= '0;
      neg_quo_q   <= 1'b0;
      neg_rem_q   <= 1'b0;
      quotient_q  <= '0;
      remainder_q <= '0;
      dbz_q       <= 1'b0;
      ovf_q       <= 1'b0;
    end else begin
      state_q     <= state_d;
      dvd_q       <= dvd_d;
      dvs_q       <= dvs_d;
      rem_q       <= rem_d;
      cnt_q       <= cnt_d;
      neg_quo_q   <= neg_quo_d;
      neg_rem_q   <= neg_rem_d;
      quotient_q  <= quotient_d;
      remainder_q <= remainder_d;
      dbz_q       <= dbz_d;
      ovf_q       <= ovf_d;
    end
  end

  assign in_ready    = (state_q == S_IDLE) & ~reset;
  assign out_valid   = (state_q == S_DONE);
  assign quotient    = quotient_q;
  assign remainder   = remainder_q;
  assign div_by_zero = dbz_q;
  assign overflow    = ovf_q;

endmodule

// File: tb/tb_divider_iter.sv
// Directed bench for divider_iter: instance 0 uses one bit per cycle, and
// instance 1 uses two bits per cycle. Both use 32-bit operands. Latency is
// counted as rising edges after the accepting edge until out_valid is seen.
module tb_divider_iter;

  logic        clk = 1'b0;
  logic        reset;
  logic        in_valid  [2];
  logic        in_ready  [2];
  logic        in_signed [2];
  logic [31:0] dividend  [2];
  logic [31:0] divisor   [2];
  logic        out_valid [2];
  logic        out_ready [2];
  logic [31:0] quo       [2];
  logic [31:0] rem       [2];
  logic        dbz       [2];
  logic        ovf       [2];

  int total = 0;
  int bad   = 0;

  always #5 clk = ~clk;

  divider_iter #(.BIT_DEPTH(32), .BITS_PER_CYCLE(1)) dut1 (
    .clk(clk), .reset(reset),
    .in_valid(in_valid[0]), .in_ready(in_ready[0]), .in_signed(in_signed[0]),
    .dividend_in(dividend[0]), .divisor_in(divisor[0]),
    .out_valid(out_valid[0]), .out_ready(out_ready[0]),
    .quotient(quo[0]), .remainder(rem[0]),
    .div_by_zero(dbz[0]), .overflow(ovf[0])
  );

  divider_iter #(.BIT_DEPTH(32), .BITS_PER_CYCLE(2)) dut2 (
    .clk(clk), .reset(reset),
    .in_valid(in_valid[1]), .in_ready(in_ready[1]), .in_signed(in_signed[1]),
    .dividend_in(dividend[1]), .divisor_in(divisor[1]),
    .out_valid(out_valid[1]), .out_ready(out_ready[1]),
    .quotient(quo[1]), .remainder(rem[1]),
    .div_by_zero(dbz[1]), .overflow(ovf[1])
  );

  task automatic chk(input string tag, input logic [31:0] observed, input logic [31:0] expected);
    total++;
    assert (observed === expected) else begin
      bad++;
      $error("FAIL %s observed=%h expected=%h", tag, observed, expected);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  // Issue one request on instance u, check latency, results and flags, then
  // hold out_ready low for 'stall' cycles before releasing the result.
  task automatic run_op(input int u, input string tag, input logic sg,
                        input logic [31:0] a, input logic [31:0] b,
                        input logic [31:0] eq, input logic [31:0] er,
                        input logic edz, input logic eov,
                        input int elat, input int stall);
    int lat;
    chk({tag, ".in_ready"}, {31'd0, in_ready[u]}, 32'd1);
    in_valid[u]  = 1'b1;
    in_signed[u] = sg;
    dividend[u]  = a;
    divisor[u]   = b;
    step();
    // Inputs outside the accepting cycle must be ignored.
    in_valid[u]  = 1'b0;
    in_signed[u] = ~sg;
    dividend[u]  = $urandom;
    divisor[u]   = $urandom;
    lat = 0;
    while (!out_valid[u] && lat < 100) begin
      step();
      lat++;
    end
    chk({tag, ".latency"}, 32'(lat), 32'(elat));
    chk({tag, ".quotient"}, quo[u], eq);
    chk({tag, ".remainder"}, rem[u], er);
    chk({tag, ".div_by_zero"}, {31'd0, dbz[u]}, {31'd0, edz});
    chk({tag, ".overflow"}, {31'd0, ovf[u]}, {31'd0, eov});
    for (int i = 0; i < stall; i++) begin
      step();
      chk({tag, ".stall_valid"}, {31'd0, out_valid[u]}, 32'd1);
      chk({tag, ".stall_in_ready"}, {31'd0, in_ready[u]}, 32'd0);
      chk({tag, ".stall_quotient"}, quo[u], eq);
      chk({tag, ".stall_remainder"}, rem[u], er);
    end
    out_ready[u] = 1'b1;
    step();
    out_ready[u] = 1'b0;
    chk({tag, ".release_valid"}, {31'd0, out_valid[u]}, 32'd0);
  endtask

  initial begin
    for (int u = 0; u < 2; u++) begin
      in_valid[u]  = 1'b0;
      in_signed[u] = 1'b0;
      dividend[u]  = '0;
      divisor[u]   = '0;
      out_ready[u] = 1'b0;
    end
    reset = 1'b1;
    step();
    step();
    chk("reset.in_ready_low", {31'd0, in_ready[0]}, 32'd0);
    chk("reset.quotient", quo[0], 32'd0);
    chk("reset.remainder", rem[0], 32'd0);
    chk("reset.out_valid", {31'd0, out_valid[0]}, 32'd0);
    chk("reset.flags", {30'd0, dbz[0], ovf[0]}, 32'd0);
    reset = 1'b0;
    #1;

    // One bit per cycle: N=32, latency 33 edges.
    run_op(0, "u_1234_56",  1'b0, 32'd1234, 32'd56, 32'd22, 32'd2, 1'b0, 1'b0, 33, 0);
    run_op(0, "s_m7_2",     1'b1, 32'hFFFF_FFF9, 32'd2, 32'hFFFF_FFFD, 32'hFFFF_FFFF, 1'b0, 1'b0, 33, 0);
    run_op(0, "s_7_m2",     1'b1, 32'd7, 32'hFFFF_FFFE, 32'hFFFF_FFFD, 32'd1, 1'b0, 1'b0, 33, 0);
    run_op(0, "u_fff9_2",   1'b0, 32'hFFFF_FFF9, 32'd2, 32'h7FFF_FFFC, 32'd1, 1'b0, 1'b0, 33, 0);
    run_op(0, "s_m7_m2",    1'b1, 32'hFFFF_FFF9, 32'hFFFF_FFFE, 32'd3, 32'hFFFF_FFFF, 1'b0, 1'b0, 33, 0);
    run_op(0, "s_5_min",    1'b1, 32'd5, 32'h8000_0000, 32'd0, 32'd5, 1'b0, 1'b0, 33, 0);
    run_op(0, "u_100_0",    1'b0, 32'd100, 32'd0, 32'd0, 32'd0, 1'b1, 1'b0, 0, 0);
    run_op(0, "s_100_0",    1'b1, 32'd100, 32'd0, 32'd0, 32'd0, 1'b1, 1'b0, 0, 0);
    run_op(0, "s_min_m1",   1'b1, 32'h8000_0000, 32'hFFFF_FFFF, 32'h8000_0000, 32'd0, 1'b0, 1'b1, 0, 0);
    run_op(0, "u_min_ff",   1'b0, 32'h8000_0000, 32'hFFFF_FFFF, 32'd0, 32'h8000_0000, 1'b0, 1'b0, 33, 0);

    // Two bits per cycle: N=16, latency 17 edges; back-to-back after release.
    run_op(1, "b2_65535_255", 1'b0, 32'd65535, 32'd255, 32'd257, 32'd0, 1'b0, 1'b0, 17, 5);
    run_op(1, "b2_1000_7",    1'b0, 32'd1000, 32'd7, 32'd142, 32'd6, 1'b0, 1'b0, 17, 0);
    run_op(1, "b2_m100_7",    1'b1, 32'hFFFF_FF9C, 32'd7, 32'hFFFF_FFF2, 32'hFFFF_FFFE, 1'b0, 1'b0, 17, 0);

    // Reset during CALC on instance 0, whose outputs still hold a nonzero remainder.
    in_valid[0]  = 1'b1;
    in_signed[0] = 1'b0;
    dividend[0]  = 32'd256;
    divisor[0]   = 32'd16;
    step();
    in_valid[0] = 1'b0;
    for (int i = 0; i < 5; i++) step();
    chk("midreset.busy", {31'd0, in_ready[0]}, 32'd0);
    reset = 1'b1;
    #1;
    chk("midreset.async_remainder", rem[0], 32'd0);
    chk("midreset.async_in_ready", {31'd0, in_ready[0]}, 32'd0);
    step();
    reset = 1'b0;
    #1;
    chk("midreset.in_ready", {31'd0, in_ready[0]}, 32'd1);
    chk("midreset.out_valid", {31'd0, out_valid[0]}, 32'd0);
    chk("midreset.quotient", quo[0], 32'd0);
    chk("midreset.flags", {30'd0, dbz[0], ovf[0]}, 32'd0);
    run_op(0, "u_256_16", 1'b0, 32'd256, 32'd16, 32'd16, 32'd0, 1'b0, 1'b0, 33, 0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/divider_iter.md
# divider_iter

Iterative restoring integer divider, the parametrised successor of the single-mode `division` block. It has a valid/ready handshake on both sides and selectable signed or unsigned operation per request. It retires a configurable number of quotient bits per cycle and reports divide-by-zero and signed-overflow flags. It sits behind the datapath as a multi-cycle execution unit: one operation in flight, with results held until they are consumed.

## Interface
- `BIT_DEPTH`, 32, operand and result width. Must be ≥ 2 and divisible by `BITS_PER_CYCLE`.
- `BITS_PER_CYCLE`, 1, restoring steps per CALC cycle. Allowed values: 1, 2 or 4.
- `clk` in 1: the single clock, rising edge.
- `reset` in 1: asynchronous, active-high; forces IDLE.
- `in_valid` in 1: request present.
- `in_ready` out 1: block accepts a request. Equals (state==IDLE) & ~reset.
- `in_signed` in 1: 1 selects two's-complement division; 0 selects unsigned.
- `dividend_in` in BIT_DEPTH: dividend.
- `divisor_in` in BIT_DEPTH: divisor.
- `out_valid` out 1: result available (state==DONE).
- `out_ready` in 1: consumer takes the result.
- `quotient` out BIT_DEPTH: registered quotient.
- `remainder` out BIT_DEPTH: registered remainder.
- `div_by_zero` out 1: set for the current result when the divisor was 0.
- `overflow` out 1: set for the current result on signed MIN / -1.

## Operation
- **States:** IDLE, CALC, FIX, DONE.
- **Reset:** state=IDLE; `quotient`, `remainder`, `div_by_zero`, `overflow`, `out_valid` = 0.

**IDLE**
- On `in_valid & in_ready`, latch the operands and `in_signed`, and clear both flags.
- Divisor = 0: quotient=0, remainder=0, `div_by_zero`=1, go to DONE.
- Signed, dividend = MIN (1 followed by zeros) and divisor = all-ones: quotient=MIN, remainder=0, `overflow`=1, go to DONE.
- Otherwise:
  - Load the working magnitudes. In signed mode use |x| as BIT_DEPTH-bit unsigned values; |MIN| = MIN pattern.
  - Record sign_q = sign(dividend) XOR sign(divisor), and sign_r = sign(dividend).
  - Clear the partial remainder (BIT_DEPTH+1 bits) and set iteration counter = BIT_DEPTH/BITS_PER_CYCLE.
  - Go to CALC.

**CALC**
- Each cycle performs `BITS_PER_CYCLE` restoring steps, MSB first. Each step:
  - Shift the next dividend bit into the partial remainder.
  - Trial-subtract the divisor magnitude.
  - If the result is non-negative, keep it and the quotient bit is 1; otherwise restore and the quotient bit is 0.
- The counter decrements once per cycle; on the cycle it equals 1, go to FIX.

**FIX**
- Signed mode uses truncating (C) semantics:
  - quotient = sign_q ? −q : q.
  - remainder = sign_r ? −r : r.
- Unsigned mode passes q and r through unchanged.
- Outputs are registered; go to DONE.

**DONE**
- `out_valid`=1; `quotient`, `remainder` and both flags are held stable.
- On `out_ready`, go to IDLE.
- `in_ready`=0 throughout; there is no overlap of consecutive operations.

**General rules**
- `quotient` and `remainder` hold their last values until overwritten at the next FIX or early-exit load. They are meaningful only while `out_valid`=1.
- `in_signed`, `dividend_in` and `divisor_in` are ignored outside the accepting cycle.

## Timing
- Let N = BIT_DEPTH/BITS_PER_CYCLE.
- **Accept:** takes place at rising edge T.
- **Normal operation:** CALC occupies edges T+1..T+N, FIX→DONE occurs at edge T+N+1, and `out_valid` rises after edge T+N+1. Latency is N+1 cycles. Defaults: 33 cycles; 17 cycles with `BITS_PER_CYCLE`=2.
- **Early exit (zero divisor, overflow):** `out_valid` rises after edge T (1 cycle).
- **Release:** with `out_valid & out_ready` at edge U, the block is in IDLE with `in_ready`=1 after U. The next accept can occur at U+1, giving a minimum issue interval of N+3 cycles.
- **Backpressure:** `out_valid` stays high and results stay constant indefinitely while `out_ready`=0.
- **Reset mid-operation (any state):** outputs go to 0 immediately and no result is produced. The first accept is possible on the first edge with `reset` low.

## Test plan
- Unsigned, BIT_DEPTH=32, BITS_PER_CYCLE=1, 1234/56 -> quotient=22, remainder=2, `out_valid` exactly 33 cycles after accept, both flags 0.
- Signed -7/2 -> quotient=0xFFFFFFFD, remainder=0xFFFFFFFF. Signed 7/-2 -> quotient=0xFFFFFFFD, remainder=1. Unsigned 0xFFFFFFF9/2 -> quotient=0x7FFFFFFC, remainder=1.
- 100/0 in both modes -> quotient=0, remainder=0, `div_by_zero`=1, `out_valid` one cycle after accept.
- Signed 0x80000000/0xFFFFFFFF -> quotient=0x80000000, remainder=0, `overflow`=1. The same operands unsigned -> quotient=0, remainder=0x80000000, `overflow`=0.
- BITS_PER_CYCLE=2, 65535/255 with `out_ready` held 0 for 5 cycles -> quotient=257, remainder=0, 17-cycle latency, outputs stable and `in_ready`=0 while stalled; a second request accepted the cycle after release completes correctly.
- Assert `reset` for one cycle during CALC of 256/16 -> all outputs 0 and `in_ready`=1 after deassertion; a following 256/16 -> quotient=16, remainder=0.
